// File: rtl/eda_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eda_scan_ctrl: raster-scan sequencer for the regional-maximum flag matrix. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

module eda_scan_ctrl #(
  parameter int M       = `CFG_M,
  parameter int N       = `CFG_N,
  parameter int I_WIDTH = `CFG_I_WIDTH,
  parameter int J_WIDTH = `CFG_J_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       rd_ready,
  output logic [I_WIDTH-1:0]         pix_i,
  output logic [J_WIDTH-1:0]         pix_j,
  output logic [I_WIDTH-1:0]         nbr_i,
  output logic [J_WIDTH-1:0]         nbr_j,
  output logic                       clear,
  output logic                       new_pixel,
  output logic                       update_strb,
  output logic [M-1:0][N-1:0]        strb_value,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic        [I_WIDTH-1:0] LAST_I = I_WIDTH'(M - 1);
  localparam logic        [J_WIDTH-1:0] LAST_J = J_WIDTH'(N - 1);
  localparam logic signed [I_WIDTH:0]   MAX_I  = (I_WIDTH + 1)'(M - 1);
  localparam logic signed [J_WIDTH:0]   MAX_J  = (J_WIDTH + 1)'(N - 1);

  function automatic logic signed [I_WIDTH:0] nbr_row(input logic [I_WIDTH-1:0] pi,
                                                      input logic [2:0] k);
    logic signed [I_WIDTH:0] d;
    case (k)
      3'd0, 3'd1, 3'd2: d = '1;
      3'd3, 3'd4:       d = '0;
      default:          d = (I_WIDTH + 1)'(1);
    endcase
    return $signed({1'b0, pi}) + d;
  endfunction

  function automatic logic signed [J_WIDTH:0] nbr_col(input logic [J_WIDTH-1:0] pj,
                                                      input logic [2:0] k);
    logic signed [J_WIDTH:0] d;
    case (k)
      3'd0, 3'd3, 3'd5: d = '1;
      3'd1, 3'd6:       d = '0;
      default:          d = (J_WIDTH + 1)'(1);
    endcase
    return $signed({1'b0, pj}) + d;
  endfunction

  function automatic logic nbr_ok(input logic [I_WIDTH-1:0] pi,
                                  input logic [J_WIDTH-1:0] pj,
                                  input logic [2:0] k);
    logic signed [I_WIDTH:0] r;
    logic signed [J_WIDTH:0] c;
    r = nbr_row(pi, k);
    c = nbr_col(pj, k);
    return !r[I_WIDTH] && (r <= MAX_I) && !c[J_WIDTH] && (c <= MAX_J);
  endfunction

  // First in-bounds neighbour index >= k0; 8 means none is left.
  function automatic logic [3:0] find_nbr(input logic [I_WIDTH-1:0] pi,
                                          input logic [J_WIDTH-1:0] pj,
                                          input logic [3:0] k0);
    logic [3:0] r;
    r = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      if (4'(k) >= k0 && nbr_ok(pi, pj, 3'(k))) r = 4'(k);
    end
    return r;
  endfunction

  state_t               r_state;
  logic [I_WIDTH-1:0]   r_ci;
  logic [J_WIDTH-1:0]   r_cj;
  logic [2:0]           r_ck;
  logic                 r_fin;

  logic [3:0]              w_next_k;
  logic [3:0]              w_np_k;
  logic                    w_final;
  logic                    w_last_pix;
  logic [I_WIDTH-1:0]      w_np_i;
  logic [J_WIDTH-1:0]      w_np_j;
  logic signed [I_WIDTH:0] w_nr;
  logic signed [J_WIDTH:0] w_nc;
  logic                    w_unused_bits;

  // r_c* is the cursor: the next comparison to be issued, one step ahead of the outputs.
  always_comb begin
    w_next_k   = find_nbr(r_ci, r_cj, {1'b0, r_ck} + 4'd1);
    w_final    = w_next_k[3];
    w_last_pix = (r_ci == LAST_I) && (r_cj == LAST_J);
    if (r_cj == LAST_J) begin
      w_np_i = r_ci + I_WIDTH'(1);
      w_np_j = '0;
    end else begin
      w_np_i = r_ci;
      w_np_j = r_cj + J_WIDTH'(1);
    end
    w_np_k        = find_nbr(w_np_i, w_np_j, 4'd0);
    w_nr          = nbr_row(r_ci, r_ck);
    w_nc          = nbr_col(r_cj, r_ck);
    w_unused_bits = ^{w_np_k[3], w_nr[I_WIDTH], w_nc[J_WIDTH]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ci        <= '0;
      r_cj        <= '0;
      r_ck        <= '0;
      r_fin       <= 1'b0;
      pix_i       <= '0;
      pix_j       <= '0;
      nbr_i       <= '0;
      nbr_j       <= '0;
      clear       <= 1'b0;
      new_pixel   <= 1'b0;
      update_strb <= 1'b0;
      strb_value  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      clear       <= 1'b0;
      new_pixel   <= 1'b0;
      update_strb <= 1'b0;
      strb_value  <= '0;
      done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Pixel (0,0) always starts at its (0,+1) neighbour.
            r_state <= S_CLEAR;
            clear   <= 1'b1;
            busy    <= 1'b1;
            r_ci    <= '0;
            r_cj    <= '0;
            r_ck    <= 3'd4;
            r_fin   <= 1'b0;
            pix_i   <= '0;
            pix_j   <= '0;
            nbr_i   <= '0;
            nbr_j   <= J_WIDTH'(1);
          end
        end
        S_CLEAR, S_SCAN: begin
          if (r_state == S_SCAN && r_fin) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_state <= S_SCAN;
            if (rd_ready) begin
              pix_i <= r_ci;
              pix_j <= r_cj;
              nbr_i <= w_nr[I_WIDTH-1:0];
              nbr_j <= w_nc[J_WIDTH-1:0];
              if (w_final) begin
                update_strb            <= 1'b1;
                strb_value[r_ci][r_cj] <= 1'b1;
                if (w_last_pix) begin
                  r_fin <= 1'b1;
                end else begin
                  r_ci <= w_np_i;
                  r_cj <= w_np_j;
                  r_ck <= w_np_k[2:0];
                end
              end else begin
                new_pixel <= 1'b1;
                r_ck      <= w_next_k[2:0];
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eda_scan_ctrl.sv
`default_nettype none
// Self-checking bench for eda_scan_ctrl: 4x4 instance (vectors, full scans, stall,
// restart, abort) and 2x2 instance (minimum image).

module tb_eda_scan_ctrl;

  localparam int S4 = 84;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset4, start4, rd4;
  logic [1:0]       pi4, pj4, ni4, nj4;
  logic             clr4, np4, up4, busy4, done4;
  logic [3:0][3:0]  strb4;

  logic             reset2, start2, rd2;
  logic [0:0]       pi2, pj2, ni2, nj2;
  logic             clr2, np2, up2, busy2, done2;
  logic [1:0][1:0]  strb2;

  eda_scan_ctrl #(.M(4), .N(4), .I_WIDTH(2), .J_WIDTH(2)) u_dut4 (
    .clk(clk), .reset(reset4), .start(start4), .rd_ready(rd4),
    .pix_i(pi4), .pix_j(pj4), .nbr_i(ni4), .nbr_j(nj4),
    .clear(clr4), .new_pixel(np4), .update_strb(up4), .strb_value(strb4),
    .busy(busy4), .done(done4));

  eda_scan_ctrl #(.M(2), .N(2), .I_WIDTH(1), .J_WIDTH(1)) u_dut2 (
    .clk(clk), .reset(reset2), .start(start2), .rd_ready(rd2),
    .pix_i(pi2), .pix_j(pj2), .nbr_i(ni2), .nbr_j(nj2),
    .clear(clr2), .new_pixel(np2), .update_strb(up2), .strb_value(strb2),
    .busy(busy2), .done(done2));

  int n_cmp = 0;
  int n_bad = 0;
  int run_errs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic dev(input int cyc, input string what);
    if (run_errs == 0) $display("  first deviation at t%0d: %s", cyc, what);
    run_errs++;
  endtask

  // Reference comparison list for a 4x4 image, raster order, listed neighbour order.
  int m_pi[S4], m_pj[S4], m_ni[S4], m_nj[S4];
  bit m_fin[S4];
  int di_t[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int dj_t[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  task automatic build_model();
    int n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < 8; k++) begin
          int r = i + di_t[k];
          int c = j + dj_t[k];
          if (r >= 0 && r < 4 && c >= 0 && c < 4 && n < S4) begin
            m_pi[n] = i; m_pj[n] = j; m_ni[n] = r; m_nj[n] = c; m_fin[n] = 1'b0;
            n++;
          end
        end
        if (n > 0) m_fin[n-1] = 1'b1;
      end
  endtask

  logic [1:0] cap_i[8], cap_j[8];
  int cap_n;

  // mode 0: plain, 1: stall during pixel (1,2), 2: start re-asserted, 3: reset at scan cycle 30
  task automatic run4(input int mode, output int done_cyc, output int upd_cnt);
    int idx = 0, stall_left = 0, li = 0, lj = 0, lni = 0, lnj = 1;
    bit armed = 1'b1, rd_s;
    logic [15:0] exp_strb;
    done_cyc = -1; upd_cnt = 0; run_errs = 0; cap_n = 0;
    @(negedge clk); start4 = 1'b1; rd4 = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("m%0d_clear_cycle", mode),
        32'({clr4, busy4, np4, up4, done4, pi4, pj4, ni4, nj4}), 32'({5'b11000, 8'b0000_0001}));
    for (int cyc = 2; cyc < 400; cyc++) begin
      @(negedge clk);
      rd_s = 1'b1;
      if (stall_left > 0) begin rd_s = 1'b0; stall_left--; end
      rd4 = rd_s;
      start4 = (mode == 2 && cyc == 12);
      if (mode == 3 && cyc == 32) begin
        reset4 = 1'b1; #1;
        chk("abort_async", 32'({busy4, clr4, np4, up4, done4, pi4, pj4, ni4, nj4, strb4}), 32'h0);
        @(posedge clk); #1;
        chk("abort_next", 32'({busy4, clr4, np4, up4, done4, pi4, pj4, ni4, nj4, strb4}), 32'h0);
        @(negedge clk); reset4 = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (up4) upd_cnt++;
      if ((np4 || up4) && pi4 == 2'd1 && pj4 == 2'd1 && cap_n < 8) begin
        cap_i[cap_n] = ni4; cap_j[cap_n] = nj4; cap_n++;
      end
      if (done4) begin
        done_cyc = cyc;
        if (idx != S4) dev(cyc, "done before last comparison");
        if (np4 || up4 || clr4 || !busy4) dev(cyc, "done-cycle outputs");
        break;
      end
      if (!busy4) dev(cyc, "busy low in scan");
      if (clr4) dev(cyc, "second clear");
      if (np4 && up4) dev(cyc, "new_pixel with update_strb");
      if (rd_s && idx < S4) begin
        if (pi4 != 2'(m_pi[idx]) || pj4 != 2'(m_pj[idx]) ||
            ni4 != 2'(m_ni[idx]) || nj4 != 2'(m_nj[idx])) dev(cyc, "coordinates");
        if (np4 != !m_fin[idx] || up4 != m_fin[idx]) dev(cyc, "strobes");
        exp_strb = m_fin[idx] ? (16'(1) << (m_pi[idx] * 4 + m_pj[idx])) : 16'h0;
        if (strb4 != exp_strb) dev(cyc, "strb_value");
        if (mode == 1 && armed && m_pi[idx] == 1 && m_pj[idx] == 2) begin
          stall_left = 2; armed = 1'b0;
        end
        li = m_pi[idx]; lj = m_pj[idx]; lni = m_ni[idx]; lnj = m_nj[idx];
        idx++;
      end else if (idx < S4) begin
        if (np4 || up4 || strb4 != 16'h0) dev(cyc, "strobe while stalled");
        if (pi4 != 2'(li) || pj4 != 2'(lj) || ni4 != 2'(lni) || nj4 != 2'(lnj))
          dev(cyc, "coordinates moved while stalled");
      end else begin
        dev(cyc, "done missing after last comparison");
      end
    end
    @(negedge clk); start4 = (mode == 2);
    @(posedge clk); #1;
    chk($sformatf("m%0d_idle_after_done", mode), 32'({busy4, clr4, done4, np4, up4}), 32'h0);
    @(negedge clk); start4 = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("m%0d_idle_hold", mode), 32'({busy4, clr4, done4, np4, up4}), 32'h0);
    chk($sformatf("m%0d_scan_errs", mode), 32'(run_errs), 32'h0);
  endtask

  typedef struct {
    logic rd;
    logic clr, np, up;
    int   pi, pj, ni, nj;
    logic [15:0] strb;
  } vec_t;

  vec_t tab[16];
  int   e11i[8] = '{0, 0, 0, 1, 1, 2, 2, 2};
  int   e11j[8] = '{0, 1, 2, 0, 2, 0, 1, 2};

  initial begin
    int dc, uc, d2, u, npc, excl;
    // rd is the rd_ready value sampled at the edge that opens the cycle.
    tab[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 16'h0000};
    tab[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 16'h0000};
    tab[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 16'h0000};
    tab[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 16'h0000};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1, 16'h0001};
    tab[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 16'h0000};
    tab[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 2, 16'h0000};
    tab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0, 16'h0000};
    tab[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 1, 16'h0000};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1, 2, 16'h0002};
    tab[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 0, 1, 16'h0000};
    tab[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 0, 3, 16'h0000};
    tab[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1, 1, 16'h0000};
    tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1, 1, 16'h0000};
    tab[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1, 2, 16'h0000};
    tab[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1, 3, 16'h0004};
    build_model();

    reset4 = 1'b1; start4 = 1'b0; rd4 = 1'b1;
    reset2 = 1'b1; start2 = 1'b0; rd2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset4 = 1'b0; reset2 = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", 32'({busy4, clr4, np4, up4, done4, pi4, pj4, ni4, nj4, strb4}), 32'h0);
    repeat (3) @(posedge clk); #1;
    chk("idle_no_start", 32'({busy4, clr4, done4}), 32'h0);

    // Directed vectors over the first three pixels, with two stall cycles.
    @(negedge clk); start4 = 1'b1; rd4 = tab[0].rd;
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      if (r > 0) begin
        @(negedge clk); start4 = 1'b0; rd4 = tab[r].rd;
        @(posedge clk); #1;
      end
      chk($sformatf("vec[%0d]", r),
          32'({clr4, tab[r].np == np4 ? np4 : ~np4, up4, busy4, pi4, pj4, ni4, nj4, strb4}),
          32'({tab[r].clr, tab[r].np, tab[r].up, 1'b1, 2'(tab[r].pi), 2'(tab[r].pj),
               2'(tab[r].ni), 2'(tab[r].nj), tab[r].strb}));
      chk($sformatf("vec[%0d]_np", r), 32'(np4), 32'(tab[r].np));
    end
    @(negedge clk); reset4 = 1'b1; rd4 = 1'b1;
    @(negedge clk); reset4 = 1'b0;

    run4(0, dc, uc);
    chk("plain_done_cycle", 32'(dc), 32'd86);
    chk("plain_updates", 32'(uc), 32'd16);
    chk("pix11_count", 32'(cap_n), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("pix11_nbr[%0d]", k), 32'({cap_i[k], cap_j[k]}),
          32'({2'(e11i[k]), 2'(e11j[k])}));

    run4(1, dc, uc);
    chk("stall_done_cycle", 32'(dc), 32'd88);
    chk("stall_updates", 32'(uc), 32'd16);

    run4(2, dc, uc);
    chk("restart_done_cycle", 32'(dc), 32'd86);
    chk("restart_updates", 32'(uc), 32'd16);

    run4(3, dc, uc);
    run4(0, dc, uc);
    chk("after_abort_done_cycle", 32'(dc), 32'd86);
    chk("after_abort_updates", 32'(uc), 32'd16);

    // 2x2 image: three neighbours per pixel.
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1;
    chk("c2_clear", 32'({clr2, busy2, np2, up2}), 32'b1100);
    @(negedge clk); start2 = 1'b0;
    d2 = -1; u = 0; npc = 0; excl = 0;
    for (int cyc = 2; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (np2 && up2) excl++;
      if (np2) npc++;
      if (up2) begin
        chk($sformatf("c2_strb%0d", u), 32'(strb2), 32'(4'(1) << u));
        u++;
      end
      if (done2) begin d2 = cyc; break; end
    end
    chk("c2_done_cycle", 32'(d2), 32'd14);
    chk("c2_updates", 32'(u), 32'd4);
    chk("c2_new_pixels", 32'(npc), 32'd8);
    chk("c2_exclusive", 32'(excl), 32'd0);
    @(posedge clk); #1;
    chk("c2_idle", 32'({busy2, done2, clr2}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
